// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic DEPTH-slice pipeline register with
// valid/ready handshake, flush-to-bubble and optional input skid.
module pipe_stage_reg #(
  parameter int DATA_W = 39,
  parameter int CTRL_W = 13,
  parameter int DEPTH  = 1,
  parameter int SKID   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [$clog2(DEPTH+2)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+2);

  logic              vld    [DEPTH];
  logic [DATA_W-1:0] dat    [DEPTH];
  logic [CTRL_W-1:0] ctl    [DEPTH];
  logic              prev_v [DEPTH];
  logic [DATA_W-1:0] prev_d [DEPTH];
  logic [CTRL_W-1:0] prev_c [DEPTH];
  logic [DEPTH-1:0]  rdy;

  logic              skid_v;
  logic [DATA_W-1:0] skid_d;
  logic [CTRL_W-1:0] skid_c;
  logic              src_v;
  logic [DATA_W-1:0] src_d;
  logic [CTRL_W-1:0] src_c;

  // A slice may load when it or any slice ahead of it has a hole.
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      r      = ~vld[i] | r;
      rdy[i] = r;
    end
  end

  // A held skid entry is older than anything on in_data.
  assign src_v = skid_v | (in_valid & in_ready);
  assign src_d = skid_v ? skid_d : in_data;
  assign src_c = skid_v ? skid_c : in_ctrl;

  always_comb begin
    prev_v[0] = src_v;
    prev_d[0] = src_d;
    prev_c[0] = src_c;
    for (int i = 1; i < DEPTH; i++) begin
      prev_v[i] = vld[i-1];
      prev_d[i] = dat[i-1];
      prev_c[i] = ctl[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld[g] <= 1'b0;
        dat[g] <= '0;
        ctl[g] <= '0;
      end else if (flush) begin
        vld[g] <= 1'b0;
        ctl[g] <= '0;
      end else if (rdy[g]) begin
        vld[g] <= prev_v[g];
        dat[g] <= prev_d[g];
        ctl[g] <= prev_c[g];
      end
    end
  end

  if (SKID != 0) begin : g_skid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_v <= 1'b0;
        skid_d <= '0;
        skid_c <= '0;
      end else if (flush) begin
        skid_v <= 1'b0;
        skid_c <= '0;
      end else if (skid_v) begin
        if (rdy[0]) begin
          skid_v <= 1'b0;
        end
      end else if (in_valid && !rdy[0]) begin
        skid_v <= 1'b1;
        skid_d <= in_data;
        skid_c <= in_ctrl;
      end
    end
    assign in_ready = ~skid_v;
  end else begin : g_noskid
    assign skid_v   = 1'b0;
    assign skid_d   = '0;
    assign skid_c   = '0;
    assign in_ready = rdy[0];
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign out_ctrl  = out_valid ? ctl[DEPTH-1] : '0;

  always_comb begin
    occupancy = OW'(skid_v);
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(vld[i]);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three configurations driven in lockstep and
// scored against a queue-based model of the handshake rules.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic [38:0] in_data;
  logic [12:0] in_ctrl;
  logic        flush;
  logic        out_ready;

  logic        iry [3];
  logic        ov  [3];
  logic [38:0] od  [3];
  logic [12:0] oc  [3];
  logic [2:0]  oq  [3];
  logic [1:0]  oq0, oq1;
  logic [2:0]  oq2;

  assign oq[0] = {1'b0, oq0};
  assign oq[1] = {1'b0, oq1};
  assign oq[2] = oq2;

  pipe_stage_reg #(.DATA_W(39), .CTRL_W(13), .DEPTH(2), .SKID(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(iry[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_ctrl(oc[0]), .occupancy(oq0));

  pipe_stage_reg #(.DATA_W(39), .CTRL_W(13), .DEPTH(1), .SKID(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(iry[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_ctrl(oc[1]), .occupancy(oq1));

  pipe_stage_reg #(.DATA_W(39), .CTRL_W(13), .DEPTH(4), .SKID(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(iry[2]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_ctrl(oc[2]), .occupancy(oq2));

  int dp [3];
  int sk [3];
  logic [51:0] mq [3][256];
  int ma [3][256];
  int hd [3];
  int tl [3];
  int t;
  bit exact;
  bit ee_seen;
  int checks;
  int errors;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check pre-edge outputs, then advance the model.
  task automatic step();
    logic a [3];
    logic e [3];
    int cnt;
    int age;
    logic exp_ir;
    #1;
    for (int i = 0; i < 3; i++) begin
      cnt = tl[i] - hd[i];
      age = t - ma[i][hd[i] % 256];
      if (sk[i] != 0) exp_ir = (cnt < dp[i] + 1);
      else exp_ir = (cnt < dp[i]) || out_ready;
      chk("occupancy", 64'(oq[i]), 64'(cnt));
      chk("in_ready", 64'(iry[i]), 64'(exp_ir));
      if (!ov[i]) begin
        chk("bubble_ctrl", 64'(oc[i]), 64'd0);
      end else begin
        chk("head_nonempty", 64'(cnt > 0), 64'd1);
        chk("head_entry", 64'({oc[i], od[i]}), 64'(mq[i][hd[i] % 256]));
        chk("latency_min", 64'(age >= dp[i] - 1), 64'd1);
      end
      if (exact)
        chk("out_valid_exact", 64'(ov[i]),
            64'(cnt > 0 && age >= dp[i] - 1));
      a[i] = in_valid && exp_ir;
      e[i] = ov[i] && out_ready;
    end
    @(posedge clk);
    t++;
    for (int i = 0; i < 3; i++) begin
      if (e[i] && (tl[i] - hd[i]) > 0) begin
        if (od[i] == 39'h0EE) ee_seen = 1'b1;
        hd[i]++;
      end
      if (flush) begin
        hd[i] = tl[i];
      end else if (a[i]) begin
        mq[i][tl[i] % 256] = {in_ctrl, in_data};
        ma[i][tl[i] % 256] = t;
        tl[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    n = 0;
    while (n < 30 && (tl[0] != hd[0] || tl[1] != hd[1] || tl[2] != hd[2]))
    begin
      step();
      n++;
    end
    for (int i = 0; i < 3; i++) chk("drain_empty", 64'(tl[i] - hd[i]), 64'd0);
  endtask

  initial begin
    dp = '{2, 1, 4};
    sk = '{1, 0, 1};
    checks = 0;
    errors = 0;
    t = 0;
    exact = 1'b0;
    ee_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", 64'(ov[i]), 64'd0);
      chk("rst_out_data", 64'(od[i]), 64'd0);
      chk("rst_out_ctrl", 64'(oc[i]), 64'd0);
      chk("rst_occupancy", 64'(oq[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // streaming
    exact = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      in_data = 39'(k);
      in_ctrl = 13'(k);
      step();
      if (k == 1) chk("stream_not_yet", 64'(ov[0]), 64'd0);
      if (k == 2) begin
        chk("stream_first_valid", 64'(ov[0]), 64'd1);
        chk("stream_first_data", 64'(od[0]), 64'd1);
      end
    end
    drain();
    exact = 1'b0;

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 13'h005;
    in_data = 39'h0AA; step();
    in_data = 39'h0BB; step();
    in_data = 39'h0CC; step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("bp_head_data", 64'(od[0]), 64'h0AA);
    chk("bp_occupancy", 64'(oq[0]), 64'd3);
    drain();

    // flush
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 13'h1FFF;
    for (int k = 1; k <= 3; k++) begin
      in_data = 39'(k + 16);
      step();
    end
    chk("pre_flush_occ", 64'(oq[0]), 64'd3);
    ee_seen = 1'b0;
    flush = 1'b1;
    in_data = 39'h0EE;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_out_valid", 64'(ov[i]), 64'd0);
      chk("flush_out_ctrl", 64'(oc[i]), 64'd0);
      chk("flush_occupancy", 64'(oq[i]), 64'd0);
    end
    drain();
    chk("flush_input_dropped", 64'(ee_seen), 64'd0);

    // accept and emit together with every slice full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 13'h002;
    in_data = 39'h011; step();
    in_data = 39'h022; step();
    chk("full_occ_before", 64'(oq[0]), 64'd2);
    out_ready = 1'b1;
    in_data = 39'h033; step();
    chk("full_occ_after", 64'(oq[0]), 64'd2);
    chk("full_order", 64'(od[0]), 64'h022);
    drain();

    // asynchronous reset with entries held
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 39'h044; step();
    in_data = 39'h055; step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_out_valid", 64'(ov[i]), 64'd0);
      chk("arst_out_ctrl", 64'(oc[i]), 64'd0);
      chk("arst_occupancy", 64'(oq[i]), 64'd0);
      hd[i] = tl[i];
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 39'h066;
    in_ctrl = 13'h0AB;
    step();
    drain();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      in_valid = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      flush = ($urandom % 32) == 0;
      in_data = {7'h40, $urandom};
      in_ctrl = 13'($urandom);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
